// File: rtl/alarm_sequencer.sv
// alarm_sequencer: arm/disarm/trigger alarm FSM with exit, entry and siren delays.
// Optional saturating trip counter, enabled by defining the macro TRIP_COUNTER_EN.
module alarm_sequencer #(
  parameter int unsigned EXIT_CYCLES  = 16,
  parameter int unsigned ENTRY_CYCLES = 16,
  parameter int unsigned SIREN_CYCLES = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       trigger,
  input  logic       arm,
  input  logic       disarm,
  output logic       siren,
  output logic       armed,
  output logic       pending,
  output logic [2:0] state,
  output logic [3:0] trip_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_ENTRY = 3'd3,
    ST_ALARM = 3'd4
  } state_e;

  // Counters are loaded with length-1 so each delay state lasts exactly its length.
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arm_q, disarm_q;
  logic             arm_rise, disarm_rise;
  logic             trip_inc;
  logic             cnt_zero;

  assign arm_rise    = arm & ~arm_q;
  assign disarm_rise = disarm & ~disarm_q;
  assign cnt_zero    = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      arm_q    <= 1'b0;
      disarm_q <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arm_q    <= arm;
      disarm_q <= disarm;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trip_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_rise && !disarm_rise) begin
          state_d = ST_EXIT;
          cnt_d   = EXIT_LOAD;
        end
      end
      ST_EXIT: begin
        if (disarm_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = ST_ARMED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ARMED: begin
        if (disarm_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (trigger) begin
          state_d = ST_ENTRY;
          cnt_d   = ENTRY_LOAD;
        end
      end
      ST_ENTRY: begin
        if (disarm_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d  = ST_ALARM;
          cnt_d    = SIREN_LOAD;
          trip_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ALARM: begin
        // Siren expiry re-arms rather than disarming the system.
        if (disarm_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = ST_ARMED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs: decoded from the state register only.
  assign state   = state_q;
  assign siren   = (state_q == ST_ALARM);
  assign armed   = (state_q == ST_ARMED) || (state_q == ST_ENTRY) || (state_q == ST_ALARM);
  assign pending = (state_q == ST_EXIT) || (state_q == ST_ENTRY);

`ifdef TRIP_COUNTER_EN
  logic [3:0] trip_q, trip_d;

  always_comb begin
    trip_d = trip_q;
    if (trip_inc && (trip_q != 4'hf)) begin
      trip_d = trip_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trip_q <= '0;
    end else if (ena) begin
      trip_q <= trip_d;
    end
  end

  assign trip_count = trip_q;
`else
  logic unused_trip_inc;
  assign unused_trip_inc = trip_inc;
  assign trip_count      = '0;
`endif

endmodule
